// File: rtl/wb_stream_burst_writer_if.sv
// Wishbone B4 master-side bus bundle used by the stream burst writer toward wb_hyper.
interface wb_stream_burst_writer_if #(
    parameter int AW = 32
) ();
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;

    modport master (
        output adr, dat, sel, we, cyc, stb, cti, bte,
        input  ack
    );

    modport slave (
        input  adr, dat, sel, we, cyc, stb, cti, bte,
        output ack
    );
endinterface

// File: rtl/wb_stream_burst_writer.sv
// Buffers a 32-bit valid/ready stream in a FIFO and writes it to consecutive
// HyperRAM addresses as wishbone incrementing bursts of up to BURST_LEN beats.
module wb_stream_burst_writer #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_LEN = 4,
    parameter int FIFO_AW   = 5,
    parameter int LW        = 24
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_adr_i,
    input  logic [LW-1:0] len_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    wb_stream_burst_writer_if.master wb
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BCW   = $clog2(BURST_LEN + 1);
    localparam logic [LW-1:0] BL = LW'(BURST_LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [AW-1:0]      r_adr;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_acc_cnt;
    logic [LW-1:0]      r_wr_rem;
    logic [BCW-1:0]     r_beat_cnt;
    logic [DW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;

    logic          w_busy;
    logic          w_burst;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_last_beat;
    logic          w_fifo_ok;
    logic [LW-1:0] w_n;

    assign w_busy      = (r_state == S_ARM) || (r_state == S_BURST);
    assign w_burst     = (r_state == S_BURST);
    assign w_full      = (r_count == (FIFO_AW + 1)'(DEPTH));
    assign s_ready_o   = w_busy && !w_full && (r_acc_cnt < r_len);
    assign w_push      = s_valid_i && s_ready_o;
    assign w_pop       = w_burst && wb.ack;
    assign w_last_beat = (r_beat_cnt == BCW'(1));
    assign w_n         = (r_wr_rem < BL) ? r_wr_rem : BL;
    assign w_fifo_ok   = (LW'(r_count) >= w_n);

    assign busy_o = w_busy;
    assign done_o = (r_state == S_DONE);

    // Bus outputs are pure functions of registered state, so they stay frozen across wait states.
    assign wb.cyc = w_burst;
    assign wb.stb = w_burst;
    assign wb.we  = w_burst;
    assign wb.sel = w_burst ? 4'hF : 4'h0;
    assign wb.cti = w_burst ? (w_last_beat ? 3'b111 : 3'b010) : 3'b000;
    assign wb.bte = 2'b00;
    assign wb.adr = r_adr;
    assign wb.dat = w_burst ? r_mem[r_rptr] : '0;

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state    <= S_IDLE;
            r_adr      <= '0;
            r_len      <= '0;
            r_acc_cnt  <= '0;
            r_wr_rem   <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_push) begin
                r_acc_cnt <= r_acc_cnt + LW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_state   <= S_ARM;
                            r_adr     <= base_adr_i & ~AW'(3);
                            r_len     <= len_i;
                            r_wr_rem  <= len_i;
                            r_acc_cnt <= '0;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                // A burst only starts once every beat it needs is already buffered.
                S_ARM: begin
                    if (w_fifo_ok) begin
                        r_beat_cnt <= BCW'(w_n);
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (wb.ack) begin
                        r_adr      <= r_adr + AW'(4);
                        r_wr_rem   <= r_wr_rem - LW'(1);
                        r_beat_cnt <= r_beat_cnt - BCW'(1);
                        if (w_last_beat) begin
                            r_state <= (r_wr_rem == LW'(1)) ? S_DONE : S_ARM;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_stream_burst_writer.md
Name: wb_stream_burst_writer

Overview:
- Upstream master for the HyperRAM wishbone controller (wb_hyper data slave port).
- Takes a 32-bit valid/ready pixel/word stream (e.g. Boson capture path) and buffers it in an internal FIFO.
- Writes a programmed number of words to consecutive HyperRAM addresses using wishbone incrementing bursts.
- Reports busy/done to the control logic.

Parameters:
- AW, 32, wishbone address width (byte address).
- DW, 32, data width; fixed at 32, sel is 4 bits.
- BURST_LEN, 4, maximum beats per wishbone burst; must be 1..2^FIFO_AW.
- FIFO_AW, 5, FIFO address bits; depth = 2^FIFO_AW words.
- LW, 24, width of the length-in-words input.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse; latches base_adr_i/len_i and begins a transfer.
- base_adr_i  in  AW  byte start address; bits [1:0] ignored (treated as 0).
- len_i  in  LW  number of 32-bit words to write.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse at completion.
- s_data_i  in  32  stream data.
- s_valid_i  in  1  stream valid.
- s_ready_o  out  1  stream ready.
- wb_adr_o  out  AW  wishbone address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte selects.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_cti_o  out  3  cycle type identifier.
- wb_bte_o  out  2  burst type extension.
- wb_ack_i  in  1  acknowledge from wb_hyper.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0: busy_o, done_o, s_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o.
  - FIFO emptied; counters cleared; FSM to IDLE.
  - Reset mid-burst drops cyc/stb immediately. Data in flight is lost; no done_o.
- Registers:
  - adr: word-aligned byte address.
  - acc_cnt: words accepted from the stream.
  - wr_rem: words remaining to write.
  - beat_cnt: beats left in the current burst.
  - FIFO count: 0..2^FIFO_AW.
- Stream side:
  - s_ready_o = busy_o & FIFO not full & acc_cnt < len.
  - A word is accepted on s_valid_i & s_ready_o; acc_cnt increments.
  - When idle, s_ready_o = 0; the stream is back-pressured, never dropped.
  - Simultaneous push and pop keeps the FIFO count unchanged.
- FSM states: IDLE, ARM, BURST, DONE.
  - IDLE: on start_i with len_i != 0 → ARM next cycle. Latch adr = {base_adr_i[AW-1:2],2'b00} and wr_rem = len_i; busy_o = 1 from that cycle.
  - IDLE, start_i with len_i == 0 → DONE; busy_o stays 0 and done_o pulses the following cycle.
  - start_i while not IDLE is ignored.
  - ARM: let n = min(BURST_LEN, wr_rem). When FIFO count >= n, load beat_cnt = n and go to BURST; cyc/stb assert in the BURST cycle. Otherwise wait.
  - BURST:
    - cyc = stb = we = 1, sel = 4'hF, bte = 2'b00.
    - wb_dat_o = FIFO head, presented combinationally from the FIFO read port, valid while stb high.
    - cti = 3'b010 while beat_cnt > 1; cti = 3'b111 on the final beat, including single-beat bursts.
    - Each cycle with wb_ack_i: pop the FIFO, adr += 4, wr_rem -= 1, beat_cnt -= 1. The next beat is presented in the following cycle.
    - No ack means every output is held stable; wait states are unlimited.
    - On the ack of the last beat: cyc/stb drop the next cycle. If wr_rem reaches 0 → DONE, else → ARM.
    - Minimum one idle cycle between bursts.
  - DONE: done_o = 1 for exactly one cycle, busy_o = 0 in the same cycle, then → IDLE.
- Arithmetic:
  - adr wraps modulo 2^AW without error.
  - acc_cnt and wr_rem are LW bits wide.
  - Bursts may cross any address boundary; the controller is linear.
- wb_ack_i outside BURST is ignored.

Test Plan:
- Single word: start base=0x0, len=1, stream 0x12345678 → one beat, adr 0x0, cti=111, sel=F. done_o pulses one cycle after the ack cycle.
- Burst of 4, BURST_LEN=4: stream 0x01020304, 0x05060708, 0x090a0b0c, 0x0d0e0f00 with base=0x0 → adr 0x0/0x4/0x8/0xC, cti 010,010,010,111, single cyc assertion. HyperRAM model readback matches.
- len=10, BURST_LEN=4: bursts of 4, 4, 2 at 0x100, 0x110, 0x120. cyc deasserts for at least one cycle between bursts. Last cti=111 at adr 0x124.
- Back-pressure: slave inserts 0–8 random wait states and the stream is held valid continuously → s_ready_o falls when the FIFO (32 words) is full. No word is lost or duplicated over 100 words; outputs stay stable during waits.
- Edge cases:
  - start with len=0 → busy_o stays 0 and done_o pulses once.
  - start_i during busy → ignored; the original transfer completes unchanged.
  - base=0x3 → first adr is 0x0.
- Reset mid-burst: assert wb_rst_n_i low during beat 2 of 4 → cyc/stb/busy_o are 0 immediately and no done_o. A new start after release writes correctly from an empty FIFO.
